rst_seq_ctrl: RTL and testbench

//  Synthesizable reset sequencer fed by the testbench/board clock and reset pair.

---
 rtl/rst_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl
//   Reset sequencer between the board clock/reset source and the per-subsystem
//   reset inputs. It synchronises the deassertion of rst_ni and then releases
//   NumDomains active-low resets one at a time, in index order, DelayCycles
//   apart. In the idle state it also serves a software reset request. That
//   request uses a four-phase req/ack handshake. All outputs go low again for
//   HoldCycles, then the outputs are re-sequenced, and the request is then
//   acknowledged.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_ni        in   asynchronous active-low reset, clears all state
//   sw_rst_req_i  in   software reset request (level, four-phase)
//   sw_rst_ack_o  out  software reset acknowledge
//   rst_no        out  per-domain active-low resets, bit 0 released first
//   seq_done_o    out  all domains released and sequencer idle
//   busy_o        out  sequence in progress (inverse of seq_done_o)
module rst_seq_ctrl #(
  parameter int NumDomains  = 4,
  parameter int DelayCycles = 8,
  parameter int HoldCycles  = 4,
  parameter int SyncStages  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_rst_req_i,
  output logic                  sw_rst_ack_o,
  output logic [NumDomains-1:0] rst_no,
  output logic                  seq_done_o,
  output logic                  busy_o
);

  localparam int MaxCnt = (DelayCycles > HoldCycles) ? DelayCycles : HoldCycles;
  localparam int CntW   = $clog2(MaxCnt + 1);
  localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_RELEASE,
    ST_DONE,
    ST_HOLD,
    ST_ACK
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumDomains-1:0] rst_no_q, rst_no_d;
  logic                  sw_q, sw_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  rst_sync;
  logic                  release_step;

  // Deassertion synchroniser: shifts in ones once rst_ni is high.
  assign sync_d   = {sync_q[SyncStages-2:0], 1'b1};
  assign rst_sync = sync_q[SyncStages-1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rst_no_d     = rst_no_q;
    sw_d         = sw_q;
    release_step = 1'b0;

    case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        idx_d = '0;
        // The edge that first sees rst_sync already counts as the first
        // delay cycle, so domain 0 releases DelayCycles edges after rst_sync.
        if (rst_sync) release_step = 1'b1;
      end
      ST_RELEASE: release_step = 1'b1;
      ST_DONE: begin
        if (sw_rst_req_i) begin
          state_d  = ST_HOLD;
          rst_no_d = '0;
          cnt_d    = '0;
        end
      end
      ST_HOLD: begin
        rst_no_d = '0;
        if (cnt_q == CntW'(HoldCycles - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
          sw_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_ACK: begin
        if (!sw_rst_req_i) state_d = ST_DONE;
      end
      default: state_d = ST_WAIT;
    endcase

    // Shared delay counting for WAIT (on sync) and RELEASE.
    if (release_step) begin
      if (cnt_q == CntW'(DelayCycles - 1)) begin
        cnt_d = '0;
        for (int i = 0; i < NumDomains; i++) begin
          if (idx_q == IdxW'(i)) rst_no_d[i] = 1'b1;
        end
        if (idx_q == IdxW'(NumDomains - 1)) begin
          state_d = sw_q ? ST_ACK : ST_DONE;
          sw_d    = 1'b0;
        end else begin
          state_d = ST_RELEASE;
          idx_d   = idx_q + IdxW'(1);
        end
      end else begin
        state_d = ST_RELEASE;
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  // Registered status outputs follow the next state.
  assign ack_d  = (state_d == ST_ACK);
  assign done_d = (state_d == ST_DONE);
  assign busy_d = ~done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_no_q <= '0;
      sw_q     <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_no_q <= rst_no_d;
      sw_q     <= sw_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sync_q   <= sync_d;
    end
  end

  assign rst_no       = rst_no_q;
  assign sw_rst_ack_o = ack_q;
  assign seq_done_o   = done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl
//   Directed bench for rst_seq_ctrl. Edge numbers are counted from the rise
//   of rst_ni. Observed outputs are packed as {rst_no, ack, done, busy}. A
//   second instance (one domain, DelayCycles=1) covers the minimal setup.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       req = 1'b0;
  logic       ack;
  logic [3:0] rst_no;
  logic       done;
  logic       busy;

  logic       req1 = 1'b0;
  logic       ack1;
  logic [0:0] rst1_no;
  logic       done1;
  logic       busy1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NumDomains(4), .DelayCycles(8), .HoldCycles(4), .SyncStages(2)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .sw_rst_req_i(req), .sw_rst_ack_o(ack),
    .rst_no(rst_no), .seq_done_o(done), .busy_o(busy)
  );

  rst_seq_ctrl #(
    .NumDomains(1), .DelayCycles(1), .HoldCycles(1), .SyncStages(2)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .sw_rst_req_i(req1), .sw_rst_ack_o(ack1),
    .rst_no(rst1_no), .seq_done_o(done1), .busy_o(busy1)
  );

  // Expected {rst_no, ack, done, busy} n edges after a plain rst_ni rise.
  function automatic logic [6:0] exp_power(int n);
    logic [3:0] b;
    logic       d;
    b = 4'b0000;
    for (int j = 0; j < 4; j++) if (n >= 10 + 8 * j) b[j] = 1'b1;
    d = (n >= 34);
    return {b, 1'b0, d, ~d};
  endfunction

  task automatic test_reset();
    rst_ni = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({rst_no, ack, done, busy} !== 7'b0000_001)
      $display("FAIL reset_state: got %b expected %b", {rst_no, ack, done, busy}, 7'b0000_001);
    else n_pass++;
  endtask

  task automatic test_power_on();
    rst_ni = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({rst_no, ack, done, busy} !== exp_power(n))
        $display("FAIL power_on edge %0d: got %b expected %b", n, {rst_no, ack, done, busy}, exp_power(n));
      else n_pass++;
    end
  endtask

  task automatic test_sw_reset();
    logic [6:0] e;
    logic [3:0] b;
    req = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      b = 4'b0000;
      for (int j = 0; j < 4; j++) if (k >= 13 + 8 * j) b[j] = 1'b1;
      e = {b, (k >= 37), 1'b0, 1'b1};
      n_chk++;
      if ({rst_no, ack, done, busy} !== e)
        $display("FAIL sw_reset k=%0d: got %b expected %b", k, {rst_no, ack, done, busy}, e);
      else n_pass++;
    end
    req = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({rst_no, ack, done, busy} !== 7'b1111_010)
        $display("FAIL sw_ack_release k=%0d: got %b expected %b", k, {rst_no, ack, done, busy}, 7'b1111_010);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({rst_no, ack, done, busy} !== exp_power(n))
        $display("FAIL abort_pre edge %0d: got %b expected %b", n, {rst_no, ack, done, busy}, exp_power(n));
      else n_pass++;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({rst_no, ack, done, busy} !== 7'b0000_001)
      $display("FAIL abort_async: got %b expected %b", {rst_no, ack, done, busy}, 7'b0000_001);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({rst_no, ack, done, busy} !== exp_power(n))
        $display("FAIL abort_reseq edge %0d: got %b expected %b", n, {rst_no, ack, done, busy}, exp_power(n));
      else n_pass++;
    end
  endtask

  task automatic test_early_req();
    logic [6:0] e;
    logic [3:0] b;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    req    = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      @(posedge clk); #1;
      if (n <= 34) begin
        e = exp_power(n);
      end else begin
        b = 4'b0000;
        for (int j = 0; j < 4; j++) if (n >= 47 + 8 * j) b[j] = 1'b1;
        e = {b, (n == 71), (n >= 72), (n < 72)};
      end
      n_chk++;
      if ({rst_no, ack, done, busy} !== e)
        $display("FAIL early_req edge %0d: got %b expected %b", n, {rst_no, ack, done, busy}, e);
      else n_pass++;
      if (n == 36) req = 1'b0;
    end
  endtask

  task automatic test_glitch();
    #2;
    rst_ni = 1'b0;
    #0.1;
    n_chk++;
    if ({rst_no, ack, done, busy} !== 7'b0000_001)
      $display("FAIL glitch_low: got %b expected %b", {rst_no, ack, done, busy}, 7'b0000_001);
    else n_pass++;
    #0.1;
    rst_ni = 1'b1;
    #0.1;
    n_chk++;
    if ({rst_no, ack, done, busy} !== 7'b0000_001)
      $display("FAIL glitch_after: got %b expected %b", {rst_no, ack, done, busy}, 7'b0000_001);
    else n_pass++;
    for (int n = 1; n <= 36; n++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({rst_no, ack, done, busy} !== exp_power(n))
        $display("FAIL glitch_reseq edge %0d: got %b expected %b", n, {rst_no, ack, done, busy}, exp_power(n));
      else n_pass++;
    end
  endtask

  task automatic test_single_domain();
    logic [3:0] e;
    rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({rst1_no, ack1, done1, busy1} !== 4'b0001)
      $display("FAIL single_reset: got %b expected %b", {rst1_no, ack1, done1, busy1}, 4'b0001);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      e = {(n >= 3), 1'b0, (n >= 3), (n < 3)};
      n_chk++;
      if ({rst1_no, ack1, done1, busy1} !== e)
        $display("FAIL single_domain edge %0d: got %b expected %b", n, {rst1_no, ack1, done1, busy1}, e);
      else n_pass++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_abort();
    test_early_req();
    test_glitch();
    test_single_domain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
